// File: rtl/router_pkg.sv
// Shared types and constants for the router packet FIFO: read FSM states,
// header length field position and default geometry.
package router_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 16;

  // Header length field occupies bits [LEN_MSB:LEN_LSB] of a tagged byte
  localparam int unsigned LEN_LSB = 2;
  localparam int unsigned LEN_MSB = DEF_DATA_W - 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } rd_state_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for the packet FIFO: synchronous write, registered read
// port, plus a combinational view of the head entry for header decode.
module router_fifo_mem #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_q,
  output logic [WIDTH-1:0]  o_peek
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_q;

  // Read and write never target the same slot: reads need !empty, writes !full
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_q <= r_mem[i_rd_addr];
  end

  assign o_rd_q = r_rd_q;
  assign o_peek = r_mem[i_rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware per-destination output FIFO of the 1x3 router.
// Optional drop statistics (ovf, drop_cnt) when ROUTER_PKT_FIFO_STATS_EN is defined.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_enb,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic                     sof_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_done,
  output logic                     err_trunc,
  output logic                     err_orphan
`ifdef ROUTER_PKT_FIFO_STATS_EN
  ,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned ENT_W  = DATA_W + 1;
  localparam int unsigned REM_W  = DATA_W - 1;
  localparam int unsigned LEN_W  = DATA_W - LEN_LSB;

  logic [PTR_W-1:0]  r_wptr, r_rptr, w_count;
  logic              w_empty, w_full, w_wr_acc, w_rd_acc, w_clr;
  logic [ENT_W-1:0]  w_peek, w_rd_q;
  logic              w_peek_tag;
  logic [LEN_W-1:0]  w_peek_len;
  logic [LEN_LSB-1:0] w_unused_peek;

  rd_state_t         r_state, w_nxt_state;
  logic [REM_W-1:0]  r_rem, w_nxt_rem;
  logic              w_nxt_done, w_nxt_trunc, w_nxt_orphan;
  logic              r_done, r_trunc, r_orphan, r_valid, r_out_live;

  assign w_clr    = reset || soft_reset;
  assign w_count  = r_wptr - r_rptr;
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_wr_acc = write_enb && !w_full && !w_clr;
  assign w_rd_acc = read_enb && !w_empty && !w_clr;

  router_fifo_mem #(
    .WIDTH  (ENT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr[ADDR_W-1:0]),
    .i_wr_data ({lfd_state, data_in}),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rptr[ADDR_W-1:0]),
    .o_rd_q    (w_rd_q),
    .o_peek    (w_peek)
  );

  assign w_peek_tag    = w_peek[DATA_W];
  assign w_peek_len    = w_peek[DATA_W-1:LEN_LSB];
  assign w_unused_peek = w_peek[LEN_LSB-1:0];

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd_acc) r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Read FSM next state: tracks bytes remaining (payload + parity) in the current packet
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_rem    = r_rem;
    w_nxt_done   = 1'b0;
    w_nxt_trunc  = 1'b0;
    w_nxt_orphan = 1'b0;
    if (w_rd_acc) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_peek_tag) begin
            w_nxt_rem   = REM_W'(w_peek_len) + REM_W'(1);
            w_nxt_state = ST_BODY;
          end else begin
            w_nxt_orphan = 1'b1;
          end
        end
        ST_BODY: begin
          if (w_peek_tag) begin
            w_nxt_trunc = 1'b1;
            w_nxt_rem   = REM_W'(w_peek_len) + REM_W'(1);
          end else begin
            w_nxt_rem = r_rem - REM_W'(1);
            if (r_rem == REM_W'(1)) begin
              w_nxt_done  = 1'b1;
              w_nxt_state = ST_IDLE;
            end
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state  <= ST_IDLE;
      r_rem    <= '0;
      r_done   <= 1'b0;
      r_trunc  <= 1'b0;
      r_orphan <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_rem    <= w_nxt_rem;
      r_done   <= w_nxt_done;
      r_trunc  <= w_nxt_trunc;
      r_orphan <= w_nxt_orphan;
      r_valid  <= w_rd_acc;
    end
  end

  // The array read register has no reset; mask it to zero until the first read after reset
  always_ff @(posedge clk) begin
    if (reset)         r_out_live <= 1'b0;
    else if (w_rd_acc) r_out_live <= 1'b1;
  end

  assign data_out    = r_out_live ? w_rd_q[DATA_W-1:0] : '0;
  assign sof_out     = r_out_live && w_rd_q[DATA_W];
  assign data_valid  = r_valid;
  assign pkt_done    = r_done;
  assign err_trunc   = r_trunc;
  assign err_orphan  = r_orphan;
  assign empty       = w_empty;
  assign full        = w_full;
  assign count       = w_count;
  assign almost_full = (w_count >= PTR_W'(DEPTH - AF_MARGIN));

`ifdef ROUTER_PKT_FIFO_STATS_EN
  logic       r_ovf;
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (write_enb && w_full) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: directed vector table, corner-case
// sequences and randomized traffic against a queue-based packet model.
module tb_router_pkt_fifo;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 2;

  logic              clk = 1'b0;
  logic              reset, soft_reset, write_enb, lfd_state, read_enb;
  logic [DATA_W-1:0] data_in, data_out;
  logic              data_valid, sof_out, empty, full, almost_full;
  logic [4:0]        count;
  logic              pkt_done, err_trunc, err_orphan;
`ifdef ROUTER_PKT_FIFO_STATS_EN
  logic              ovf;
  logic [7:0]        drop_cnt;
`endif

  always #5 clk = ~clk;

  router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .data_valid(data_valid),
    .sof_out(sof_out), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .pkt_done(pkt_done), .err_trunc(err_trunc), .err_orphan(err_orphan)
`ifdef ROUTER_PKT_FIFO_STATS_EN
    , .ovf(ovf), .drop_cnt(drop_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of tagged bytes and a "bytes left in packet" counter
  typedef struct { logic tag; logic [7:0] data; } ent_t;
  ent_t       q[$];
  logic [7:0] m_dout;
  logic       m_sof, m_valid, m_done, m_trunc, m_orphan, m_ovf;
  int         m_left, m_drops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input bit hard);
    q.delete();
    m_valid = 0; m_done = 0; m_trunc = 0; m_orphan = 0;
    m_left = 0; m_ovf = 0; m_drops = 0;
    if (hard) begin m_dout = 8'h00; m_sof = 1'b0; end
  endtask

  task automatic model_step(input bit we, input bit lfd, input logic [7:0] din,
                            input bit re, input bit sr);
    bit   was_full;
    ent_t e;
    was_full = (q.size() == DEPTH);
    if (sr) begin
      model_clear(0);
    end else begin
      m_valid = 0; m_done = 0; m_trunc = 0; m_orphan = 0;
      if (we && was_full) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
      if (re && q.size() > 0) begin
        e = q.pop_front();
        m_dout = e.data; m_sof = e.tag; m_valid = 1;
        if (e.tag) begin
          if (m_left > 0) m_trunc = 1;
          m_left = int'(e.data) / 4 + 1;
        end else if (m_left == 0) begin
          m_orphan = 1;
        end else begin
          m_left--;
          if (m_left == 0) m_done = 1;
        end
      end
      if (we && !was_full) q.push_back('{tag: lfd, data: din});
    end
  endtask

  task automatic check_all();
    chk("data_valid",  32'(data_valid),  32'(m_valid));
    chk("data_out",    32'(data_out),    32'(m_dout));
    chk("sof_out",     32'(sof_out),     32'(m_sof));
    chk("pkt_done",    32'(pkt_done),    32'(m_done));
    chk("err_trunc",   32'(err_trunc),   32'(m_trunc));
    chk("err_orphan",  32'(err_orphan),  32'(m_orphan));
    chk("count",       32'(count),       32'(q.size()));
    chk("empty",       32'(empty),       32'(q.size() == 0));
    chk("full",        32'(full),        32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - AF_MARGIN));
`ifdef ROUTER_PKT_FIFO_STATS_EN
    chk("ovf",         32'(ovf),         32'(m_ovf));
    chk("drop_cnt",    32'(drop_cnt),    32'(m_drops));
`endif
  endtask

  // One clock: drive inputs, step the model with pre-edge rules, compare after the edge
  task automatic step(input bit we, input bit lfd, input logic [7:0] din,
                      input bit re, input bit sr);
    write_enb = we; lfd_state = lfd; data_in = din; read_enb = re; soft_reset = sr;
    @(posedge clk);
    #1;
    model_step(we, lfd, din, re, sr);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1; write_enb = 0; lfd_state = 0; data_in = 0; read_enb = 0; soft_reset = 0;
    @(posedge clk);
    #1;
    reset = 0;
    model_clear(1);
    check_all();
  endtask

  typedef struct {
    logic we, lfd; logic [7:0] din; logic re;
    logic ev; logic [7:0] ed; logic es, edn, eerr; int ec;
  } vec_t;
  vec_t tv[11];

  initial begin
    int n_done;
    bit trunc_on_04;
    logic [7:0] held;

    reset = 1; soft_reset = 0; write_enb = 0; lfd_state = 0; data_in = 0; read_enb = 0;
    model_clear(1);

    // Single well-formed packet: header 0x0C (len 3), payload, parity
    tv[0]  = '{1,1,8'h0C,0, 0,8'h00,0,0,0, 1};
    tv[1]  = '{1,0,8'h11,0, 0,8'h00,0,0,0, 2};
    tv[2]  = '{1,0,8'h22,0, 0,8'h00,0,0,0, 3};
    tv[3]  = '{1,0,8'h33,0, 0,8'h00,0,0,0, 4};
    tv[4]  = '{1,0,8'h5A,0, 0,8'h00,0,0,0, 5};
    tv[5]  = '{0,0,8'h00,1, 1,8'h0C,1,0,0, 4};
    tv[6]  = '{0,0,8'h00,1, 1,8'h11,0,0,0, 3};
    tv[7]  = '{0,0,8'h00,1, 1,8'h22,0,0,0, 2};
    tv[8]  = '{0,0,8'h00,1, 1,8'h33,0,0,0, 1};
    tv[9]  = '{0,0,8'h00,1, 1,8'h5A,0,1,0, 0};
    tv[10] = '{0,0,8'h00,0, 0,8'h5A,0,0,0, 0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tv[i].we, tv[i].lfd, tv[i].din, tv[i].re, 0);
      chk($sformatf("tv%0d_valid", i), 32'(data_valid), 32'(tv[i].ev));
      chk($sformatf("tv%0d_dout",  i), 32'(data_out),   32'(tv[i].ed));
      chk($sformatf("tv%0d_sof",   i), 32'(sof_out),    32'(tv[i].es));
      chk($sformatf("tv%0d_done",  i), 32'(pkt_done),   32'(tv[i].edn));
      chk($sformatf("tv%0d_err",   i), 32'(err_trunc | err_orphan), 32'(tv[i].eerr));
      chk($sformatf("tv%0d_count", i), 32'(count),      32'(tv[i].ec));
    end

    // Fill to full, drop a 17th write, drain in order
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd16);
`ifdef ROUTER_PKT_FIFO_STATS_EN
    chk("ovf_after_drop", 32'(ovf), 32'd1);
    chk("drop_cnt_after_drop", 32'(drop_cnt), 32'd1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk($sformatf("drain%0d", i), 32'(data_out), 32'(8'h40 + i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Steady count under simultaneous read/write; pointers wrap past 31
    for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 8'($urandom), 1, 0);
      chk("rw_count", 32'(count), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, 0);

    // Truncated packet followed by a complete one
    do_reset();
    step(1, 1, 8'h14, 0, 0);
    step(1, 0, 8'hA1, 0, 0);
    step(1, 0, 8'hA2, 0, 0);
    step(1, 1, 8'h04, 0, 0);
    step(1, 0, 8'hB1, 0, 0);
    step(1, 0, 8'hB2, 0, 0);
    n_done = 0; trunc_on_04 = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 8'h00, 1, 0);
      if (pkt_done) n_done++;
      if (err_trunc && data_out == 8'h04) trunc_on_04 = 1;
    end
    chk("trunc_done_count", 32'(n_done), 32'd1);
    chk("trunc_on_hdr04", 32'(trunc_on_04), 32'd1);
    chk("trunc_final_done", 32'(pkt_done), 32'd1);

    // Orphan byte popped from IDLE
    do_reset();
    step(1, 0, 8'h77, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("orphan_flag", 32'(err_orphan), 32'd1);
    chk("orphan_dout", 32'(data_out), 32'h77);
    chk("orphan_valid", 32'(data_valid), 32'd1);

    // Soft reset flushes, ignores same-cycle read/write, holds data_out
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'hD0 + i), 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    held = 8'hD1;
    step(1, 0, 8'hEE, 1, 1);
    chk("sr_empty", 32'(empty), 32'd1);
    chk("sr_count", 32'(count), 32'd0);
    chk("sr_valid", 32'(data_valid), 32'd0);
    chk("sr_hold_dout", 32'(data_out), 32'(held));
    step(1, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("sr_next_hdr_ok", 32'(err_trunc | err_orphan), 32'd0);

    // Randomized traffic with occasional flushes and bursts of fullness
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit we, re;
      int bias;
      bias = ((i / 300) % 2 == 0) ? 70 : 35;
      we = ($urandom_range(0, 99) < bias);
      re = ($urandom_range(0, 99) < 100 - bias);
      step(we, ($urandom_range(0, 4) == 0), 8'($urandom_range(0, 40)), re,
           ($urandom_range(0, 249) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised packet-aware FIFO; the next-generation per-destination output buffer of the 1x3 router, one instance per output port between the router register stage and the destination read interface. Stores DATA_W-bit bytes, each tagged with a start-of-packet bit. Decodes the header length field on read to track packet boundaries and flag malformed packets. Replaces the Hi-Z idle output with an explicit valid strobe.

## Interface
- DATA_W, 8: byte width; header length field is bits [DATA_W-1:2]
- DEPTH, 16: entries; power of two, at least 4
- AF_MARGIN, 2: almost_full asserts when free entries are at most AF_MARGIN

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- soft_reset  in  1  synchronous flush (destination time-out)
- write_enb  in  1  write request
- lfd_state  in  1  tag: the byte on data_in this cycle is a header
- data_in  in  DATA_W  write data
- read_enb  in  1  read request
- data_out  out  DATA_W  read data, registered
- data_valid  out  1  data_out updated this cycle
- sof_out  out  1  tag bit accompanying data_out
- empty  out  1  no entries
- full  out  1  DEPTH entries
- almost_full  out  1  count >= DEPTH-AF_MARGIN
- count  out  $clog2(DEPTH)+1  occupancy
- pkt_done  out  1  pulse: last byte (parity) of a packet delivered
- err_trunc  out  1  pulse: header popped while the previous packet was incomplete
- err_orphan  out  1  pulse: non-header byte popped outside a packet

## Operation
- Storage: DEPTH x (DATA_W+1), bit DATA_W is the tag. lfd_state is aligned with data_in; there is no internal delay.
- Pointers are ADDR_W+1 bits (ADDR_W = $clog2(DEPTH)) and wrap naturally. empty = (wptr==rptr). full = MSBs differ and low bits equal. count = wptr-rptr, modulo 2^(ADDR_W+1).
- Write accepted iff write_enb && !full. A write while full is dropped and state is unchanged.
- Read accepted iff read_enb && !empty. Next cycle: data_out and sof_out load the entry, and data_valid=1. Otherwise data_valid=0 and data_out/sof_out hold their values.
- Simultaneous read and write: both are accepted under the above rules, and count is unchanged. Flags are evaluated on pre-edge state. There is no write-to-read bypass: a write to an empty FIFO is readable the next cycle.
- Read FSM (advances on accepted reads only):
  - IDLE, tagged pop: rem <= len+1, where len = entry[DATA_W-1:2]; this covers payload plus parity. Go to BODY.
  - IDLE, untagged pop: err_orphan pulse, stay in IDLE. The byte is still delivered.
  - BODY, untagged pop: rem <= rem-1. If rem==1, pulse pkt_done and go to IDLE.
  - BODY, tagged pop: err_trunc pulse, reload rem from the new header, stay in BODY.
- rem width is DATA_W-1 bits. A header with len=0 yields a one-byte body (parity only).
- Pulses are registered and coincide with the data_valid of the triggering byte.

## Timing
- Reset (takes priority over everything else): pointers=0, FSM=IDLE, data_out=0, sof_out=0, data_valid=0, all pulses 0, empty=1, full=0, almost_full=0, count=0. Memory is not cleared.
- soft_reset (when reset is low): the same pointer, FSM, valid and pulse clearing as reset. data_out and sof_out hold their values. A write or read in the same cycle is ignored.
- Read latency: 1 cycle from accepted read_enb to data_valid.
- Flags and count are combinational from the pointers and change the cycle after an accepted write or read.
- Reset or soft_reset mid-packet: the partial packet is discarded with no error pulse. The next pop is expected to be a header.

## Configuration
- ROUTER_PKT_FIFO_STATS_EN defined: adds output ports ovf (1 bit, sticky; set by a dropped write) and drop_cnt (8 bits, saturating at 255, counts dropped writes). Both are cleared by reset and by soft_reset.
- Undefined: the ports and logic are absent. Dropped writes are silent.

## Structure
- router_pkg holds:
  - the read FSM state typedef (IDLE, BODY)
  - the header field constants (LEN_LSB=2, LEN_MSB=DATA_W-1)
  - the default DATA_W and DEPTH
- Sub-module router_fifo_mem: synchronous-write, registered-read dual-port array of DEPTH x (DATA_W+1). It has no reset. Pointer, flag and FSM logic stay in router_pkt_fifo.

## Test plan
- Reset, then write header 0x0C (len=3, tagged), payload 0x11, 0x22, 0x33 and parity 0x5A. Then read 5 -> data_out 0C,11,22,33,5A; sof_out 1,0,0,0,0; pkt_done pulses with 5A; no errors.
- Fill 16 entries and write a 17th -> full=1, count=16, the 17th is dropped. With STATS_EN: ovf=1, drop_cnt=1. Read 16 -> order preserved, empty=1.
- At count=8, assert read_enb and write_enb together for 20 cycles -> count stays 8. Pointers wrap past 31 -> 0 with no corruption.
- Write header len=5 and 2 payload bytes, then header 0x04 (len=1), 1 payload and parity. Read all -> err_trunc pulses with 0x04; pkt_done pulses once, on the final parity.
- Pop an untagged 0x77 from IDLE -> err_orphan=1, data_out=0x77, data_valid=1.
- Write 6 bytes, read 2, then assert soft_reset -> next cycle empty=1, count=0, data_valid=0; data_out holds its last value.
